// File: rtl/aes_pkg.sv
// Shared AES constants: round count, Rcon table, key-schedule states and the S-box
// used by both the key expander and the cipher's SubBytes stage.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    typedef enum logic [1:0] {IDLE, HOLD, CALC} keyexp_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-box byte lookups. With AES_KEYEXP_SBOX_REG_EN defined the result
// is registered (loaded when en is high) so the table can map onto block RAM.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    logic [31:0] sub_p0;

    always_comb begin
        sub_p0 = '0;
        for (int i = 0; i < 4; i++) begin
            sub_p0[8*i +: 8] = sbox_lookup(word_in[8*i +: 8]);
        end
    end

`ifdef AES_KEYEXP_SBOX_REG_EN
    // ---- stage p0 -> p1: registered lookup ----
    logic [31:0] sub_p1;

    always_ff @(posedge clk) begin
        if (en) begin
            sub_p1 <= sub_p0;
        end
    end

    assign word_out = sub_p1;
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, en};
    assign word_out    = sub_p0;
`endif

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule: one round key per `next`, never storing the full
// schedule. AES_KEYEXP_SBOX_REG_EN selects the registered-S-box, two-cycle step.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key_in,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         valid,
    output logic         done
);

    keyexp_state_t state, state_nxt;
    logic [127:0]  key_nxt, step_key;
    logic [3:0]    round_nxt, rcon_idx;
    logic          valid_nxt, done_nxt, sbox_en;
    logic [31:0]   rot_word, sub_word;

    function automatic logic [127:0] expand_step(input logic [127:0] key,
                                                 input logic [31:0]  sub,
                                                 input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = key[127:96] ^ sub ^ {rc, 24'h0};
        w1 = key[95:64]  ^ w0;
        w2 = key[63:32]  ^ w1;
        w3 = key[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign rot_word = {round_key[23:0], round_key[31:24]};
    assign rcon_idx = round + 4'd1;

    aes_sbox_word u_sbox (
        .clk      (clk),
        .en       (sbox_en),
        .word_in  (rot_word),
        .word_out (sub_word)
    );

    // The key stays put during CALC, so the step can reuse round and round_key as-is.
    assign step_key = expand_step(round_key, sub_word, RCON[rcon_idx]);

    always_comb begin
        state_nxt = state;
        key_nxt   = round_key;
        round_nxt = round;
        valid_nxt = valid;
        sbox_en   = 1'b0;
        case (state)
            IDLE: ;
            HOLD: begin
                if (next && round != NR) begin
`ifdef AES_KEYEXP_SBOX_REG_EN
                    sbox_en   = 1'b1;
                    state_nxt = CALC;
                    valid_nxt = 1'b0;
`else
                    key_nxt   = step_key;
                    round_nxt = round + 4'd1;
`endif
                end
            end
            CALC: begin
                key_nxt   = step_key;
                round_nxt = round + 4'd1;
                valid_nxt = 1'b1;
                state_nxt = HOLD;
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            state_nxt = HOLD;
            key_nxt   = key_in;
            round_nxt = 4'd0;
            valid_nxt = 1'b1;
        end
        done_nxt = valid_nxt && (round_nxt == NR);
    end

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round_key <= '0;
            round     <= 4'd0;
            valid     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            round_key <= key_nxt;
            round     <= round_nxt;
            valid     <= valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized bench for aes_key_expand: a FIPS-197 style reference (S-box derived from
// the GF(2^8) inverse and affine map) is checked on every cycle, plus literal vectors.
module tb_aes_key_expand;

`ifdef AES_KEYEXP_SBOX_REG_EN
    localparam int STEP_LAT = 2;
`else
    localparam int STEP_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         reset, load, next;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         valid, done;

    aes_key_expand dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .key_in    (key_in),
        .next      (next),
        .round_key (round_key),
        .round     (round),
        .valid     (valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb_m [0:255];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    logic         m_init = 1'b0;
    logic         m_valid, m_pend, m_zero;
    int           m_round;
    logic [127:0] m_base;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1; m_valid = 1'b0; m_round = 0; m_pend = 1'b0; m_zero = 1'b1;
        end else if (load) begin
            m_base = key_in; m_round = 0; m_valid = 1'b1; m_pend = 1'b0; m_zero = 1'b0;
        end else if (m_pend) begin
            m_round = m_round + 1; m_valid = 1'b1; m_pend = 1'b0;
        end else if (next && m_valid && m_round < 10) begin
            if (STEP_LAT == 1) m_round = m_round + 1;
            else begin m_valid = 1'b0; m_pend = 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("valid", 128'(valid), 128'(m_valid));
            chk("round", 128'(round), 128'(m_round));
            chk("done", 128'(done), 128'(m_valid && m_round == 10));
            if (m_zero)
                chk("round_key_reset", round_key, 128'h0);
            else if (m_valid)
                chk("round_key", round_key, model_rk(m_base, m_round));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic l, input logic n, input logic [127:0] k);
        load = l; next = n; key_in = k;
        @(negedge clk);
        cyc_cnt++;
        load = 1'b0; next = 1'b0;
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!valid && guard < 4) begin
            cyc(1'b0, 1'b0, '0);
            guard++;
        end
        if (!valid) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_valid: valid stayed %b, want 1", valid);
        end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, '0);
            wait_valid();
        end
    endtask

    localparam logic [127:0] K1   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] K1R1 = 128'hA0FAFE1788542CB123A339392A6C7605;
    localparam logic [127:0] K1RA = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
    localparam logic [127:0] K2   = 128'h000102030405060708090A0B0C0D0E0F;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int start, lat;
        logic [127:0] held;
        reset = 1'b1; load = 1'b0; next = 1'b0; key_in = '0;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        reset = 1'b0;
        chk("reset_valid", 128'(valid), 128'h0);
        chk("reset_key", round_key, 128'h0);

        // model pins
        chk("model_sbox00", 128'(sb_m[8'h00]), 128'h63);
        chk("model_sbox53", 128'(sb_m[8'h53]), 128'hED);
        chk("model_k1_r10", model_rk(K1, 10), K1RA);

        // next while not valid is ignored
        cyc(1'b0, 1'b1, '0);
        chk("idle_next_valid", 128'(valid), 128'h0);

        cyc(1'b1, 1'b0, K1);
        chk("load_key", round_key, K1);
        chk("load_round", 128'(round), 128'h0);
        advance(1);
        chk("r1_key", round_key, K1R1);
        chk("r1_round", 128'(round), 128'h1);

        // ten requests from round 0, back-to-back when the step is single-cycle
        cyc(1'b1, 1'b0, K1);
        start = cyc_cnt;
        advance(10);
        lat = cyc_cnt - start;
        chk("r10_latency", 128'(lat), 128'(10 * STEP_LAT));
        chk("r10_key", round_key, K1RA);
        chk("r10_done", 128'(done), 128'h1);

        held = round_key;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
        chk("sat_round", 128'(round), 128'd10);
        chk("sat_key", round_key, held);
        chk("sat_done", 128'(done), 128'h1);

        // load beats next at round 3
        cyc(1'b1, 1'b0, K1);
        advance(3);
        cyc(1'b1, 1'b1, K2);
        chk("ldnext_round", 128'(round), 128'h0);
        chk("ldnext_key", round_key, K2);

`ifdef AES_KEYEXP_SBOX_REG_EN
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        chk("calc_next_round", 128'(round), 128'h1);
        cyc(1'b0, 1'b0, '0);
        chk("calc_next_hold", 128'(round), 128'h1);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, K1);
        chk("calc_load_round", 128'(round), 128'h0);
        chk("calc_load_key", round_key, K1);
`endif

        // all-zero and all-one keys through the whole schedule
        cyc(1'b1, 1'b0, '0);
        advance(10);
        cyc(1'b1, 1'b0, {128{1'b1}});
        advance(10);

        // reset mid-schedule at round 5
        cyc(1'b1, 1'b0, K1);
        advance(5);
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0);
        reset = 1'b0;
        chk("midrst_valid", 128'(valid), 128'h0);
        chk("midrst_round", 128'(round), 128'h0);
        chk("midrst_key", round_key, 128'h0);
        chk("midrst_done", 128'(done), 128'h0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            r = $urandom;
            reset = (r[15:8] == 8'h00);
            cyc(r[7:4] == 4'h0, r[0] | r[1], {$urandom, $urandom, $urandom, $urandom});
            reset = 1'b0;
        end
        cyc(1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
